dmem_port_arbiter: RTL

DMEM_PORT_ARBITER -- requirements
Module: dmem_port_arbiter

---
 rtl/dmem_arb_pkg.sv | 18 +
 rtl/dmem_rsp_buf.sv | 51 +++++
 rtl/dmem_port_arbiter.sv | 128 ++++++++++++
 3 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-requester data-memory port arbiter.
package dmem_arb_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;
    localparam int MASK_W     = 4;

    // A write mask of all zeros marks a read command.
    localparam logic [MASK_W-1:0] RD_MASK = 4'b0000;

    // Identifies requester 0 or requester 1.
    typedef logic req_id_t;

    function automatic logic is_read(input logic [MASK_W-1:0] wmask);
        return (wmask == RD_MASK);
    endfunction

endpackage

// File: rtl/dmem_rsp_buf.sv
// One-entry read-response buffer: loaded from the memory read word,
// held until the requester takes it with valid&ready.
module dmem_rsp_buf
    import dmem_arb_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data
);

    logic              valid_d, valid_q;
    logic [DATA_W-1:0] data_d, data_q;

    // Next-state: a load always wins; otherwise a handshake empties the entry.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (valid_q && rsp_ready) begin
            valid_d = 1'b0;
        end
        if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
        end
    end

    // Occupancy flag; an asynchronous reset discards any held response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Payload register; it is only observable while valid_q is set, so it needs no reset.
    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

    assign rsp_valid = valid_q;
    // Show zero whenever empty so stale data never leaks out, including during reset.
    assign rsp_data  = valid_q ? data_q : '0;

endmodule

// File: rtl/dmem_port_arbiter.sv
// Two-requester arbiter in front of a single synchronous data-memory port.
// Round-robin between eligible requesters; reads are tracked for one cycle
// and their data captured into a per-requester response buffer.
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              r0_req_valid,
    output logic              r0_req_ready,
    input  logic [ADDR_W-1:0] r0_req_addr,
    input  logic [MASK_W-1:0] r0_req_wmask,
    input  logic [DATA_W-1:0] r0_req_wdata,
    output logic              r0_rsp_valid,
    input  logic              r0_rsp_ready,
    output logic [DATA_W-1:0] r0_rsp_data,
    input  logic              r1_req_valid,
    output logic              r1_req_ready,
    input  logic [ADDR_W-1:0] r1_req_addr,
    input  logic [MASK_W-1:0] r1_req_wmask,
    input  logic [DATA_W-1:0] r1_req_wdata,
    output logic              r1_rsp_valid,
    input  logic              r1_rsp_ready,
    output logic [DATA_W-1:0] r1_rsp_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [MASK_W-1:0] mem_wmask,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_data
);

    logic    pend_valid_d, pend_valid_q;
    req_id_t pend_id_d, pend_id_q;
    req_id_t last_grant_d, last_grant_q;

    logic r0_is_rd, r1_is_rd;
    logic r0_elig, r1_elig;
    logic gnt0, gnt1;
    logic r0_buf_valid, r1_buf_valid;
    logic r0_load, r1_load;

    // Eligibility and round-robin grant; a read waits until its requester
    // has nothing in flight and room (or a draining entry) in its buffer.
    always_comb begin
        r0_is_rd = is_read(r0_req_wmask);
        r1_is_rd = is_read(r1_req_wmask);
        r0_elig  = !rst && r0_req_valid &&
                   (!r0_is_rd || (!(pend_valid_q && pend_id_q == 1'b0) &&
                                  (!r0_buf_valid || r0_rsp_ready)));
        r1_elig  = !rst && r1_req_valid &&
                   (!r1_is_rd || (!(pend_valid_q && pend_id_q == 1'b1) &&
                                  (!r1_buf_valid || r1_rsp_ready)));
        gnt0 = r0_elig && (!r1_elig || last_grant_q == 1'b1);
        gnt1 = r1_elig && (!r0_elig || last_grant_q == 1'b0);
    end

    assign r0_req_ready = gnt0;
    assign r1_req_ready = gnt1;

    // Memory port mux: the granted command goes straight out, idle drives zeros.
    always_comb begin
        mem_addr  = '0;
        mem_wmask = '0;
        mem_wdata = '0;
        if (gnt0) begin
            mem_addr  = r0_req_addr;
            mem_wmask = r0_req_wmask;
            mem_wdata = r0_req_wdata;
        end else if (gnt1) begin
            mem_addr  = r1_req_addr;
            mem_wmask = r1_req_wmask;
            mem_wdata = r1_req_wdata;
        end
    end

    // Next-state for the in-flight read tracker and the round-robin pointer.
    always_comb begin
        pend_valid_d = (gnt0 && r0_is_rd) || (gnt1 && r1_is_rd);
        pend_id_d    = gnt1 ? 1'b1 : 1'b0;
        last_grant_d = last_grant_q;
        if (gnt0 || gnt1) begin
            last_grant_d = gnt1 ? 1'b1 : 1'b0;
        end
    end

    // Control state; reset drops any in-flight read and gives r0 first turn.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_valid_q <= 1'b0;
            pend_id_q    <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            pend_valid_q <= pend_valid_d;
            pend_id_q    <= pend_id_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Memory returns the word one cycle after the address, so steer it by the tracker.
    assign r0_load = pend_valid_q && (pend_id_q == 1'b0);
    assign r1_load = pend_valid_q && (pend_id_q == 1'b1);

    dmem_rsp_buf #(.DATA_W(DATA_W)) u_r0_buf (
        .clk       (clk),
        .rst       (rst),
        .load      (r0_load),
        .load_data (mem_data),
        .rsp_valid (r0_buf_valid),
        .rsp_ready (r0_rsp_ready),
        .rsp_data  (r0_rsp_data)
    );

    dmem_rsp_buf #(.DATA_W(DATA_W)) u_r1_buf (
        .clk       (clk),
        .rst       (rst),
        .load      (r1_load),
        .load_data (mem_data),
        .rsp_valid (r1_buf_valid),
        .rsp_ready (r1_rsp_ready),
        .rsp_data  (r1_rsp_data)
    );

    assign r0_rsp_valid = r0_buf_valid;
    assign r1_rsp_valid = r1_buf_valid;

endmodule
